// File: rtl/data_mem_responder.sv
// ============================================================================
// data_mem_responder : MEM-stage data port with fixed multi-cycle latency,
//                      combinational stall and one-cycle ready/err pulses.
// Rev 1.0
// ============================================================================
`default_nettype none

module data_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  stall,
    output logic                  err
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;
    localparam int c_CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_is_write;
    logic                  r_err_flag;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_ready;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];

    logic                  w_req;
    logic                  w_bad;
    logic [ADDR_WIDTH-1:0] w_index;
    logic                  w_fire;
    logic                  w_acc_write;
    logic                  w_acc_err;
    logic [ADDR_WIDTH-1:0] w_acc_index;
    logic [DATA_WIDTH-1:0] w_acc_wdata;

    assign w_req   = req_read | req_write;
    assign w_index = addr[ADDR_WIDTH+1:2];
    assign w_bad   = (addr[1:0] != 2'b00) || (addr[31:ADDR_WIDTH+2] != '0)
                   || (req_read && req_write);

    // Single-cycle latency accesses straight from the ports; longer latencies
    // use the request captured at acceptance.
    if (LATENCY == 1) begin : g_lat1
        assign w_fire      = (r_state == c_IDLE) && w_req;
        assign w_acc_write = req_write;
        assign w_acc_err   = w_bad;
        assign w_acc_index = w_index;
        assign w_acc_wdata = wdata;
    end else begin : g_latn
        assign w_fire      = (r_state == c_WAIT) && (r_cnt == c_CNT_ONE);
        assign w_acc_write = r_is_write;
        assign w_acc_err   = r_err_flag;
        assign w_acc_index = r_index;
        assign w_acc_wdata = r_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_is_write <= 1'b0;
            r_err_flag <= 1'b0;
            r_index    <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        r_is_write <= req_write;
                        r_err_flag <= w_bad;
                        r_index    <= w_index;
                        r_wdata    <= wdata;
                        if (w_fire) begin
                            r_state <= c_DONE;
                        end else begin
                            r_state <= c_WAIT;
                            r_cnt   <= c_CNT_LOAD;
                        end
                    end
                end
                c_WAIT: begin
                    if (w_fire) begin
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
            if (w_fire) begin
                r_ready <= 1'b1;
                r_err   <= w_acc_err;
                if (!w_acc_err && !w_acc_write) begin
                    r_rdata <= r_mem[w_acc_index];
                end
            end
        end
    end

    // Array is not reset; gating on rst keeps an aborted write from landing.
    always_ff @(posedge clk) begin
        if (!rst && w_fire && !w_acc_err && w_acc_write) begin
            r_mem[w_acc_index] <= w_acc_wdata;
        end
    end

    always_comb begin
        stall = 1'b0;
        case (r_state)
            c_IDLE:  stall = w_req;
            c_WAIT:  stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    assign rdata = r_rdata;
    assign ready = r_ready;
    assign err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// tb_data_mem_responder : directed vectors for LATENCY=3 and LATENCY=1 builds.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_rd = 1'b0, a_wr = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0, a_rdata;
    logic        a_ready, a_stall, a_err;
    logic        b_rd = 1'b0, b_wr = 1'b0;
    logic [31:0] b_addr = '0, b_wdata = '0, b_rdata;
    logic        b_ready, b_stall, b_err;

    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_read(a_rd), .req_write(a_wr), .addr(a_addr),
        .wdata(a_wdata), .rdata(a_rdata), .ready(a_ready), .stall(a_stall), .err(a_err)
    );

    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_read(b_rd), .req_write(b_wr), .addr(b_addr),
        .wdata(b_wdata), .rdata(b_rdata), .ready(b_ready), .stall(b_stall), .err(b_err)
    );

    typedef struct {
        int          lat;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int lat, input logic rd, input logic wr,
                         input logic [31:0] ad, input logic [31:0] wd);
        if (lat == 1) begin
            b_rd = rd; b_wr = wr; b_addr = ad; b_wdata = wd;
        end else begin
            a_rd = rd; a_wr = wr; a_addr = ad; a_wdata = wd;
        end
    endtask

    task automatic sample(input int lat, output logic st, output logic rdy,
                          output logic er, output logic [31:0] rdv);
        if (lat == 1) begin
            st = b_stall; rdy = b_ready; er = b_err; rdv = b_rdata;
        end else begin
            st = a_stall; rdy = a_ready; er = a_err; rdv = a_rdata;
        end
    endtask

    task automatic add(input int lat, input logic rd, input logic wr, input logic [31:0] ad,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_er);
        vec_t v;
        v.lat = lat; v.rd = rd; v.wr = wr; v.addr = ad; v.wdata = wd;
        v.exp_rdata = exp_rd; v.exp_err = exp_er;
        vecs.push_back(v);
    endtask

    // Request asserted for cycle t0; stall expected t0..t0+lat-1, ready at t0+lat.
    task automatic run_txn(input int idx, input vec_t v);
        logic        st, rdy, er;
        logic [31:0] rdv;
        @(negedge clk);
        drive(v.lat, v.rd, v.wr, v.addr, v.wdata);
        for (int k = 0; k < v.lat; k++) begin
            #1;
            sample(v.lat, st, rdy, er, rdv);
            check($sformatf("v%0d stall c%0d", idx, k), {31'b0, st}, 32'd1);
            check($sformatf("v%0d ready_early c%0d", idx, k), {31'b0, rdy}, 32'd0);
            @(negedge clk);
        end
        #1;
        sample(v.lat, st, rdy, er, rdv);
        check($sformatf("v%0d ready", idx), {31'b0, rdy}, 32'd1);
        check($sformatf("v%0d stall_done", idx), {31'b0, st}, 32'd0);
        check($sformatf("v%0d err", idx), {31'b0, er}, {31'b0, v.exp_err});
        check($sformatf("v%0d rdata", idx), rdv, v.exp_rdata);
        drive(v.lat, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ready_cnt;

        // LATENCY=3 vectors
        add(3, 1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0000, 1'b0);
        add(3, 1'b1, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0);
        add(3, 1'b0, 1'b1, 32'h0000_0000, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0);
        add(3, 1'b1, 1'b0, 32'h0000_0013, 32'h0,        32'hDEADBEEF, 1'b1);
        add(3, 1'b0, 1'b1, 32'h0000_1000, 32'h55555555, 32'hDEADBEEF, 1'b1);
        add(3, 1'b1, 1'b0, 32'h0000_0000, 32'h0,        32'hA5A5A5A5, 1'b0);
        add(3, 1'b1, 1'b1, 32'h0000_0010, 32'h0BADBAD0, 32'hA5A5A5A5, 1'b1);
        add(3, 1'b1, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0);
        add(3, 1'b0, 1'b1, 32'h0000_0FFC, 32'h0BADF00D, 32'hDEADBEEF, 1'b0);
        add(3, 1'b1, 1'b0, 32'h0000_0FFC, 32'h0,        32'h0BADF00D, 1'b0);
        add(3, 1'b1, 1'b0, 32'h8000_0000, 32'h0,        32'h0BADF00D, 1'b1);
        add(3, 1'b1, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0);
        // LATENCY=1 vectors
        add(1, 1'b0, 1'b1, 32'h0000_0000, 32'h12345678, 32'h0000_0000, 1'b0);
        add(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0,        32'h12345678, 1'b0);
        add(1, 1'b0, 1'b1, 32'h0000_0004, 32'h87654321, 32'h12345678, 1'b0);
        add(1, 1'b1, 1'b0, 32'h0000_0004, 32'h0,        32'h87654321, 1'b0);
        add(1, 1'b1, 1'b0, 32'h0000_0002, 32'h0,        32'h87654321, 1'b1);
        add(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0,        32'h12345678, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst ready3", {31'b0, a_ready}, 32'd0);
        check("rst stall3", {31'b0, a_stall}, 32'd0);
        check("rst err3",   {31'b0, a_err},   32'd0);
        check("rst rdata3", a_rdata,          32'd0);
        check("rst ready1", {31'b0, b_ready}, 32'd0);
        check("rst rdata1", b_rdata,          32'd0);
        rst = 1'b0;

        foreach (vecs[i]) run_txn(i, vecs[i]);

        // Held read through DONE: ready at c3 and again at c7, nothing between.
        @(negedge clk);
        drive(3, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        ready_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (a_ready) ready_cnt++;
            check($sformatf("held ready c%0d", c), {31'b0, a_ready},
                  {31'b0, (c == 3 || c == 7)});
            check($sformatf("held stall c%0d", c), {31'b0, a_stall},
                  {31'b0, !(c == 3 || c == 7)});
        end
        check("held rdata", a_rdata, 32'hDEADBEEF);
        check("held ready_count", ready_cnt, 32'd2);
        drive(3, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset mid-access aborts a pending write.
        @(negedge clk);
        drive(3, 1'b0, 1'b1, 32'h0000_0020, 32'hCAFEF00D);
        #1;
        check("abort stall t0", {31'b0, a_stall}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort ready t1", {31'b0, a_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(3, 1'b0, 1'b0, 32'h0, 32'h0);
        ready_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (a_ready) ready_cnt++;
            check($sformatf("abort stall c%0d", c), {31'b0, a_stall}, 32'd0);
            @(negedge clk);
        end
        check("abort ready_count", ready_cnt, 32'd0);
        begin
            vec_t v;
            v.lat = 3; v.rd = 1'b1; v.wr = 1'b0; v.addr = 32'h0000_0020; v.wdata = 32'h0;
            v.exp_rdata = 32'h0; v.exp_err = 1'b0;
            // Word 0x20 was never written, so write a known value first, then abort again.
            v.rd = 1'b0; v.wr = 1'b1; v.wdata = 32'h11111111;
            run_txn(100, v);
            @(negedge clk);
            drive(3, 1'b0, 1'b1, 32'h0000_0020, 32'hCAFEF00D);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
            #1;
            check("abort2 ready t2", {31'b0, a_ready}, 32'd0);
            @(negedge clk);
            rst = 1'b0;
            drive(3, 1'b0, 1'b0, 32'h0, 32'h0);
            v.rd = 1'b1; v.wr = 1'b0; v.wdata = 32'h0; v.exp_rdata = 32'h11111111;
            run_txn(101, v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
